// File: rtl/uc_ciclo_medida_pkg.sv
// Shared definitions for the monitoring-cycle control unit: state codes and
// the class codes produced by the classifier.
package uc_ciclo_medida_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    ESPERA_1S     = 4'd2,
    MEDE          = 4'd3,
    ESPERA_MEDIDA = 4'd4,
    ANALISA       = 4'd5,
    ESPERA_CLASS  = 4'd6,
    ATUA          = 4'd7,
    TRANSMITE     = 4'd8,
    ESPERA_CHAR   = 4'd9,
    PROX_CHAR     = 4'd10,
    FALHA         = 4'd11,
    ESPERA_2S     = 4'd12,
    FIM           = 4'd13
  } estado_t;

  localparam logic [2:0] CLS_NORMAL = 3'b000;
  localparam logic [2:0] CLS_BAIXO  = 3'b001;
  localparam logic [2:0] CLS_ALTO   = 3'b010;
  localparam logic [2:0] CLS_CRIT   = 3'b011;

endpackage

// File: rtl/uc_ciclo_medida.sv
// Control unit (Moore FSM) that sequences one monitoring cycle of the
// datapath: settle, measure, classify with retry, act, report, hold.
// Optional feature: define MEDIDA_TIMEOUT_EN to bound the wait for
// fim_medida to TIMEOUT_CICLOS clocks; a timeout counts as a discard.
//
// Handshake: every fim_* input is a strobe/level from the datapath that is
// only looked at in the state waiting for it; all outputs here are decoded
// from registered state, so a strobe is high for exactly the cycle the FSM
// spends in the issuing state.
module uc_ciclo_medida
  import uc_ciclo_medida_pkg::*;
#(
  parameter int MAX_TENT       = 3,
  parameter int W_TENT         = 2,
  parameter int TIMEOUT_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       zera,
  input  logic       ligar,
  input  logic       fim_medida,
  input  logic       fim_classificacao,
  input  logic [2:0] medida_classificacao,
  input  logic       descartar_medida,
  input  logic       fim_1s,
  input  logic       fim_2s,
  input  logic       fim_carater,
  input  logic       fim_mensagem,
  output logic       zera_fd,
  output logic       conta_1s,
  output logic       conta_2s,
  output logic       mensurar,
  output logic       analisa_medida,
  output logic       envia,
  output logic       muda,
  output logic       liga_buzzer_baixa,
  output logic       liga_buzzer_alta,
  output logic       desliga_buzzers,
  output logic       abre_valvula_auto,
  output logic       fecha_valvula_auto,
  output logic       erro_sensor,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t           r_estado;
  estado_t           w_prox;
  logic [W_TENT-1:0] r_tent;
  logic [2:0]        r_classe;
  logic              r_erro;
  logic              w_timeout;
  logic              w_ultima_tent;
  logic              w_descarte;

  // The attempt that is being discarded now is the last one allowed.
  assign w_ultima_tent = (({1'b0, r_tent} + 1'b1) == (W_TENT+1)'(MAX_TENT));

`ifdef MEDIDA_TIMEOUT_EN
  localparam int W_CNT = $clog2(TIMEOUT_CICLOS + 1);
  logic [W_CNT-1:0] r_cnt_timeout;

  // Counts clocks spent in ESPERA_MEDIDA; any other state clears it, so it
  // starts at zero on every entry.
  always_ff @(posedge clock) begin
    if (zera || r_estado != ESPERA_MEDIDA) r_cnt_timeout <= '0;
    else                                   r_cnt_timeout <= r_cnt_timeout + 1'b1;
  end

  assign w_timeout = (r_estado == ESPERA_MEDIDA) &&
                     (r_cnt_timeout == W_CNT'(TIMEOUT_CICLOS - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // A discard is either an inconsistent classification or a measurement timeout.
  assign w_descarte = ((r_estado == ESPERA_CLASS) && fim_classificacao && descartar_medida) ||
                      ((r_estado == ESPERA_MEDIDA) && !fim_medida && w_timeout);

  // State register.
  always_ff @(posedge clock) begin
    if (zera) r_estado <= INICIAL;
    else      r_estado <= w_prox;
  end

  // Next-state logic.
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:       if (ligar) w_prox = PREPARA;
      PREPARA:       w_prox = ESPERA_1S;
      ESPERA_1S:     if (!ligar) w_prox = INICIAL;
                     else if (fim_1s) w_prox = MEDE;
      MEDE:          w_prox = ESPERA_MEDIDA;
      ESPERA_MEDIDA: if (fim_medida) w_prox = ANALISA;
                     else if (w_descarte) w_prox = w_ultima_tent ? FALHA : MEDE;
      ANALISA:       w_prox = ESPERA_CLASS;
      ESPERA_CLASS:  if (fim_classificacao) begin
                       if (descartar_medida) w_prox = w_ultima_tent ? FALHA : MEDE;
                       else                  w_prox = ATUA;
                     end
      ATUA:          w_prox = TRANSMITE;
      TRANSMITE:     w_prox = ESPERA_CHAR;
      ESPERA_CHAR:   if (fim_carater) w_prox = fim_mensagem ? ESPERA_2S : PROX_CHAR;
      PROX_CHAR:     w_prox = TRANSMITE;
      FALHA:         w_prox = ESPERA_2S;
      ESPERA_2S:     if (fim_2s) w_prox = FIM;
      FIM:           w_prox = ligar ? PREPARA : INICIAL;
      default:       w_prox = INICIAL;
    endcase
  end

  // Attempt counter: cleared at the start of each cycle, saturating on discards.
  always_ff @(posedge clock) begin
    if (zera || r_estado == PREPARA) r_tent <= '0;
    else if (w_descarte && r_tent != W_TENT'(MAX_TENT)) r_tent <= r_tent + 1'b1;
  end

  // Class code captured with a good classification so ATUA acts on a stable value.
  always_ff @(posedge clock) begin
    if (zera) r_classe <= CLS_NORMAL;
    else if (r_estado == ESPERA_CLASS && fim_classificacao && !descartar_medida)
      r_classe <= medida_classificacao;
  end

  // Sticky sensor error: raised together with FALHA, dropped with the next ATUA.
  always_ff @(posedge clock) begin
    if (zera)                  r_erro <= 1'b0;
    else if (w_prox == FALHA)  r_erro <= 1'b1;
    else if (w_prox == ATUA)   r_erro <= 1'b0;
  end

  // Moore output decode from the registered state and captured class.
  always_comb begin
    zera_fd            = 1'b0;
    conta_1s           = 1'b0;
    conta_2s           = 1'b0;
    mensurar           = 1'b0;
    analisa_medida     = 1'b0;
    envia              = 1'b0;
    muda               = 1'b0;
    liga_buzzer_baixa  = 1'b0;
    liga_buzzer_alta   = 1'b0;
    desliga_buzzers    = 1'b0;
    abre_valvula_auto  = 1'b0;
    fecha_valvula_auto = 1'b0;
    pronto             = 1'b0;
    case (r_estado)
      PREPARA:   zera_fd        = 1'b1;
      ESPERA_1S: conta_1s       = 1'b1;
      MEDE:      mensurar       = 1'b1;
      ANALISA:   analisa_medida = 1'b1;
      ATUA: begin
        case (r_classe)
          CLS_BAIXO: begin
            liga_buzzer_baixa = 1'b1;
            abre_valvula_auto = 1'b1;
          end
          CLS_ALTO: begin
            liga_buzzer_alta   = 1'b1;
            fecha_valvula_auto = 1'b1;
          end
          CLS_CRIT: begin
            liga_buzzer_alta   = 1'b1;
            liga_buzzer_baixa  = 1'b1;
            fecha_valvula_auto = 1'b1;
          end
          default: desliga_buzzers = 1'b1;  // NORMAL and unused codes 1xx
        endcase
      end
      TRANSMITE: envia = 1'b1;
      PROX_CHAR: muda  = 1'b1;
      FALHA: begin
        liga_buzzer_alta   = 1'b1;
        fecha_valvula_auto = 1'b1;
      end
      ESPERA_2S: conta_2s = 1'b1;
      FIM:       pronto   = 1'b1;
      default: ;
    endcase
  end

  assign erro_sensor = r_erro;
  assign db_estado   = r_estado;

endmodule

// File: tb/tb_uc_ciclo_medida.sv
// Directed bench for uc_ciclo_medida; emulates the datapath by hand and checks
// the state code and strobes cycle by cycle.
module tb_uc_ciclo_medida;

  logic       clock = 1'b0;
  logic       zera = 1'b0, ligar = 1'b0;
  logic       fim_medida = 1'b0, fim_classificacao = 1'b0, descartar_medida = 1'b0;
  logic [2:0] medida_classificacao = 3'b000;
  logic       fim_1s = 1'b0, fim_2s = 1'b0, fim_carater = 1'b0, fim_mensagem = 1'b0;
  logic       zera_fd, conta_1s, conta_2s, mensurar, analisa_medida, envia, muda;
  logic       liga_buzzer_baixa, liga_buzzer_alta, desliga_buzzers;
  logic       abre_valvula_auto, fecha_valvula_auto, erro_sensor, pronto;
  logic [3:0] db_estado;
  logic [13:0] saidas;

  int checks = 0;
  int errors = 0;
  int n_envia = 0, n_muda = 0, n_mensurar = 0;
  int s_envia, s_muda, s_mensurar;

  uc_ciclo_medida #(.MAX_TENT(3), .W_TENT(2), .TIMEOUT_CICLOS(10)) dut (
    .clock(clock), .zera(zera), .ligar(ligar),
    .fim_medida(fim_medida), .fim_classificacao(fim_classificacao),
    .medida_classificacao(medida_classificacao), .descartar_medida(descartar_medida),
    .fim_1s(fim_1s), .fim_2s(fim_2s), .fim_carater(fim_carater), .fim_mensagem(fim_mensagem),
    .zera_fd(zera_fd), .conta_1s(conta_1s), .conta_2s(conta_2s), .mensurar(mensurar),
    .analisa_medida(analisa_medida), .envia(envia), .muda(muda),
    .liga_buzzer_baixa(liga_buzzer_baixa), .liga_buzzer_alta(liga_buzzer_alta),
    .desliga_buzzers(desliga_buzzers), .abre_valvula_auto(abre_valvula_auto),
    .fecha_valvula_auto(fecha_valvula_auto), .erro_sensor(erro_sensor),
    .pronto(pronto), .db_estado(db_estado)
  );

  assign saidas = {zera_fd, conta_1s, conta_2s, mensurar, analisa_medida, envia, muda,
                   liga_buzzer_baixa, liga_buzzer_alta, desliga_buzzers,
                   abre_valvula_auto, fecha_valvula_auto, erro_sensor, pronto};

  // clock / strobe counters
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (envia)    n_envia++;
    if (muda)     n_muda++;
    if (mensurar) n_mensurar++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // From MEDE: one measurement + classification; ends in the state after ESPERA_CLASS.
  task automatic measure(input logic desc, input logic [2:0] cls, input logic [3:0] exp_next);
    tick();
    checks++; if (db_estado !== 4'd4) begin errors++; $display("FAIL meas_espera_medida: got %0d want 4", db_estado); end
    fim_medida = 1'b1;
    tick();
    fim_medida = 1'b0;
    checks++; if ({db_estado, analisa_medida} !== {4'd5, 1'b1}) begin errors++; $display("FAIL meas_analisa: state %0d analisa %0b want 5/1", db_estado, analisa_medida); end
    tick();
    checks++; if (db_estado !== 4'd6) begin errors++; $display("FAIL meas_espera_class: got %0d want 6", db_estado); end
    fim_classificacao = 1'b1; descartar_medida = desc; medida_classificacao = cls;
    tick();
    fim_classificacao = 1'b0; descartar_medida = 1'b0;
    checks++; if (db_estado !== exp_next) begin errors++; $display("FAIL meas_next: got %0d want %0d", db_estado, exp_next); end
  endtask

  // From ATUA: 4-character report, 2 s hold, FIM; ends in PREPARA or INICIAL.
  task automatic report_and_finish(input logic ligar_fim);
    s_envia = n_envia; s_muda = n_muda;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if ({db_estado, envia} !== {4'd8, 1'b1}) begin errors++; $display("FAIL rep_transmite[%0d]: state %0d envia %0b want 8/1", k, db_estado, envia); end
      tick();
      fim_carater = 1'b1; fim_mensagem = (k == 3);
      tick();
      fim_carater = 1'b0; fim_mensagem = 1'b0;
      if (k < 3) begin
        checks++; if ({db_estado, muda} !== {4'd10, 1'b1}) begin errors++; $display("FAIL rep_prox_char[%0d]: state %0d muda %0b want 10/1", k, db_estado, muda); end
      end
    end
    checks++; if ({db_estado, conta_2s} !== {4'd12, 1'b1}) begin errors++; $display("FAIL rep_espera_2s: state %0d conta_2s %0b want 12/1", db_estado, conta_2s); end
    checks++; if (n_envia - s_envia !== 4) begin errors++; $display("FAIL rep_envia_count: got %0d want 4", n_envia - s_envia); end
    checks++; if (n_muda - s_muda !== 3) begin errors++; $display("FAIL rep_muda_count: got %0d want 3", n_muda - s_muda); end
    fim_2s = 1'b1;
    tick();
    fim_2s = 1'b0;
    checks++; if ({db_estado, pronto} !== {4'd13, 1'b1}) begin errors++; $display("FAIL rep_fim: state %0d pronto %0b want 13/1", db_estado, pronto); end
    ligar = ligar_fim;
    tick();
    checks++; if (db_estado !== (ligar_fim ? 4'd1 : 4'd0)) begin errors++; $display("FAIL rep_after_fim: got %0d want %0d", db_estado, ligar_fim ? 1 : 0); end
  endtask

  task automatic test_reset();
    zera = 1'b1; ligar = 1'b0;
    tick(); tick();
    zera = 1'b0;
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", db_estado); end
    checks++; if (saidas !== 14'b0) begin errors++; $display("FAIL reset_outputs: got %b want 0", saidas); end
    tick();
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", db_estado); end
    ligar = 1'b1;
    tick();
    checks++; if ({db_estado, zera_fd} !== {4'd1, 1'b1}) begin errors++; $display("FAIL prepara: state %0d zera_fd %0b want 1/1", db_estado, zera_fd); end
    tick();
    checks++; if ({db_estado, conta_1s, zera_fd} !== {4'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL espera_1s: state %0d conta_1s %0b zera_fd %0b want 2/1/0", db_estado, conta_1s, zera_fd); end
  endtask

  task automatic test_ciclo_normal();
    fim_1s = 1'b1;
    tick();
    fim_1s = 1'b0;
    checks++; if ({db_estado, mensurar} !== {4'd3, 1'b1}) begin errors++; $display("FAIL normal_mede: state %0d mensurar %0b want 3/1", db_estado, mensurar); end
    measure(1'b0, 3'b001, 4'd7);
    checks++; if ({liga_buzzer_baixa, abre_valvula_auto, liga_buzzer_alta, fecha_valvula_auto, desliga_buzzers} !== 5'b11000) begin
      errors++; $display("FAIL normal_atua_baixo: got %b want 11000", {liga_buzzer_baixa, abre_valvula_auto, liga_buzzer_alta, fecha_valvula_auto, desliga_buzzers}); end
    report_and_finish(1'b1);
    tick();
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL normal_restart: got %0d want 2", db_estado); end
  endtask

  task automatic test_retentativas();
    fim_1s = 1'b1;
    tick();
    fim_1s = 1'b0;
    s_mensurar = n_mensurar;
    measure(1'b1, 3'b000, 4'd3);
    measure(1'b1, 3'b000, 4'd3);
    measure(1'b0, 3'b101, 4'd7);
    checks++; if (n_mensurar - s_mensurar !== 3) begin errors++; $display("FAIL retry_mensurar_count: got %0d want 3", n_mensurar - s_mensurar); end
    checks++; if (erro_sensor !== 1'b0) begin errors++; $display("FAIL retry_erro: got %0b want 0", erro_sensor); end
    checks++; if ({desliga_buzzers, liga_buzzer_alta, liga_buzzer_baixa} !== 3'b100) begin errors++; $display("FAIL retry_class_1xx_normal: got %b want 100", {desliga_buzzers, liga_buzzer_alta, liga_buzzer_baixa}); end
    report_and_finish(1'b1);
    tick();
  endtask

  task automatic test_falha();
    fim_1s = 1'b1;
    tick();
    fim_1s = 1'b0;
    s_envia = n_envia;
    measure(1'b1, 3'b000, 4'd3);
    measure(1'b1, 3'b000, 4'd3);
    measure(1'b1, 3'b000, 4'd11);
    checks++; if ({erro_sensor, fecha_valvula_auto, liga_buzzer_alta} !== 3'b111) begin errors++; $display("FAIL falha_outputs: got %b want 111", {erro_sensor, fecha_valvula_auto, liga_buzzer_alta}); end
    tick();
    checks++; if (db_estado !== 4'd12) begin errors++; $display("FAIL falha_to_2s: got %0d want 12", db_estado); end
    fim_2s = 1'b1;
    tick();
    fim_2s = 1'b0;
    tick();
    checks++; if ({db_estado, erro_sensor} !== {4'd1, 1'b1}) begin errors++; $display("FAIL falha_sticky: state %0d erro %0b want 1/1", db_estado, erro_sensor); end
    checks++; if (n_envia - s_envia !== 0) begin errors++; $display("FAIL falha_no_report: envia %0d want 0", n_envia - s_envia); end
    tick();
    fim_1s = 1'b1;
    tick();
    fim_1s = 1'b0;
    measure(1'b0, 3'b010, 4'd7);
    checks++; if ({erro_sensor, liga_buzzer_alta, fecha_valvula_auto, liga_buzzer_baixa} !== 4'b0110) begin
      errors++; $display("FAIL falha_recover_alto: got %b want 0110", {erro_sensor, liga_buzzer_alta, fecha_valvula_auto, liga_buzzer_baixa}); end
    report_and_finish(1'b0);
  endtask

  task automatic test_ignora_fim();
    ligar = 1'b1;
    tick(); tick();
    fim_medida = 1'b1; fim_carater = 1'b1; fim_classificacao = 1'b1; fim_2s = 1'b1;
    tick();
    fim_medida = 1'b0; fim_carater = 1'b0; fim_classificacao = 1'b0; fim_2s = 1'b0;
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL ignore_stray_fim: got %0d want 2", db_estado); end
    ligar = 1'b0;
    tick();
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL ligar_off_in_1s: got %0d want 0", db_estado); end
  endtask

  task automatic test_zera_meio();
    ligar = 1'b1;
    tick(); tick();
    fim_1s = 1'b1;
    tick();
    fim_1s = 1'b0;
    measure(1'b0, 3'b011, 4'd7);
    checks++; if ({liga_buzzer_alta, liga_buzzer_baixa, fecha_valvula_auto, abre_valvula_auto} !== 4'b1110) begin
      errors++; $display("FAIL crit_outputs: got %b want 1110", {liga_buzzer_alta, liga_buzzer_baixa, fecha_valvula_auto, abre_valvula_auto}); end
    tick(); tick();
    checks++; if (db_estado !== 4'd9) begin errors++; $display("FAIL zera_setup: got %0d want 9", db_estado); end
    zera = 1'b1; ligar = 1'b0;
    tick();
    zera = 1'b0;
    checks++; if ({db_estado, saidas} !== {4'd0, 14'b0}) begin errors++; $display("FAIL zera_abort: state %0d outputs %b want 0/0", db_estado, saidas); end
    s_envia = n_envia; s_muda = n_muda;
    for (int i = 0; i < 20; i++) begin
      fim_carater = i[0]; fim_mensagem = i[1];
      tick();
    end
    fim_carater = 1'b0; fim_mensagem = 1'b0;
    checks++; if ({n_envia - s_envia, n_muda - s_muda} !== {32'd0, 32'd0}) begin errors++; $display("FAIL zera_no_strobes: envia %0d muda %0d want 0/0", n_envia - s_envia, n_muda - s_muda); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL zera_stays_idle: got %0d want 0", db_estado); end
  endtask

`ifdef MEDIDA_TIMEOUT_EN
  task automatic test_timeout();
    ligar = 1'b1;
    tick(); tick();
    fim_1s = 1'b1;
    tick();
    fim_1s = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      for (int c = 0; c < 9; c++) tick();
      checks++; if (db_estado !== 4'd4) begin errors++; $display("FAIL timeout_wait[%0d]: got %0d want 4", t, db_estado); end
      tick();
      checks++; if (db_estado !== ((t < 2) ? 4'd3 : 4'd11)) begin errors++; $display("FAIL timeout_expire[%0d]: got %0d want %0d", t, db_estado, (t < 2) ? 3 : 11); end
    end
    checks++; if (erro_sensor !== 1'b1) begin errors++; $display("FAIL timeout_erro: got %0b want 1", erro_sensor); end
    ligar = 1'b0;
    tick();
    fim_2s = 1'b1;
    tick();
    fim_2s = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_ciclo_normal();
    test_retentativas();
    test_falha();
    test_ignora_fim();
    test_zera_meio();
`ifdef MEDIDA_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL time_limit: bench still running at 200000 want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
